// File: rtl/seg7_mux_driver.sv
// Purpose: scans a double-buffered 4-digit hex value onto a multiplexed 7-segment display.
// Latency: io_seg/io_sel are registered, one cycle behind the scan state; loads commit at the frame end.
// Backpressure: none. Loads are always accepted, the last one before the frame end wins, and pending reports a queued value.
module seg7_mux_driver #(
    parameter int DIGIT_PERIOD = 100000,
    parameter int BLANK_CYCLES = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    input  logic        data_valid,
    output logic        pending,
    output logic        frame_start,
    output logic [7:0]  io_seg,
    output logic [3:0]  io_sel
);

    localparam int               CNT_W     = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_PERIOD - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       dig;
    logic             slot_end;
    logic             frame_end;

    logic [15:0] shadow_data;
    logic [3:0]  shadow_dp;
    logic [3:0]  shadow_blank;
    logic [15:0] disp_data;
    logic [3:0]  disp_dp;
    logic [3:0]  disp_blank;

    logic [3:0]  nibble;
    logic [7:0]  seg_nxt;
    logic [3:0]  sel_nxt;

    function automatic logic [6:0] seg_font(input logic [3:0] v);
        seg_font = 7'h00;
        case (v)
            4'h0: seg_font = 7'h3F;
            4'h1: seg_font = 7'h06;
            4'h2: seg_font = 7'h5B;
            4'h3: seg_font = 7'h4F;
            4'h4: seg_font = 7'h66;
            4'h5: seg_font = 7'h6D;
            4'h6: seg_font = 7'h7D;
            4'h7: seg_font = 7'h07;
            4'h8: seg_font = 7'h7F;
            4'h9: seg_font = 7'h6F;
            4'hA: seg_font = 7'h77;
            4'hB: seg_font = 7'h7C;
            4'hC: seg_font = 7'h39;
            4'hD: seg_font = 7'h5E;
            4'hE: seg_font = 7'h79;
            4'hF: seg_font = 7'h71;
            default: seg_font = 7'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // IDLE holds the scan at slot 0; the first enabled edge in IDLE opens a fresh frame.
    always_comb begin
        state_nxt = state;
        slot_end  = 1'b0;
        frame_end = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_nxt = ST_IDLE;
                end else begin
                    slot_end  = (cnt == CNT_LAST);
                    frame_end = slot_end && (dig == 2'd3);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            dig         <= 2'd0;
            frame_start <= 1'b0;
        end else if (state != ST_RUN || !en) begin
            cnt         <= '0;
            dig         <= 2'd0;
            frame_start <= en && (state == ST_IDLE);
        end else begin
            frame_start <= frame_end;
            if (slot_end) begin
                cnt <= '0;
                dig <= dig + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // A load landing exactly on the frame end bypasses the shadow, so nothing is left pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_data  <= 16'h0000;
            shadow_dp    <= 4'h0;
            shadow_blank <= 4'h0;
            disp_data    <= 16'h0000;
            disp_dp      <= 4'h0;
            disp_blank   <= 4'hF;
            pending      <= 1'b0;
        end else begin
            if (data_valid) begin
                shadow_data  <= data_in;
                shadow_dp    <= dp_in;
                shadow_blank <= blank_in;
            end
            if (frame_end) begin
                pending <= 1'b0;
                if (data_valid) begin
                    disp_data  <= data_in;
                    disp_dp    <= dp_in;
                    disp_blank <= blank_in;
                end else if (pending) begin
                    disp_data  <= shadow_data;
                    disp_dp    <= shadow_dp;
                    disp_blank <= shadow_blank;
                end
            end else if (data_valid) begin
                pending <= 1'b1;
            end
        end
    end

    always_comb begin
        nibble  = disp_data[{dig, 2'b00} +: 4];
        seg_nxt = 8'hFF;
        sel_nxt = 4'hF;
        if (en && (cnt >= BLANK_END) && !disp_blank[dig]) begin
            sel_nxt = ~(4'b0001 << dig);
            seg_nxt = ~{disp_dp[dig], seg_font(nibble)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            io_seg <= 8'hFF;
            io_sel <= 4'hF;
        end else begin
            io_seg <= seg_nxt;
            io_sel <= sel_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Directed bench for seg7_mux_driver with an 8-cycle slot and a 2-cycle blanking gap (32-cycle frame).
module tb_seg7_mux_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        data_valid;
    logic        pending;
    logic        frame_start;
    logic [7:0]  io_seg;
    logic [3:0]  io_sel;

    int checks = 0;
    int errors = 0;

    seg7_mux_driver #(
        .DIGIT_PERIOD(8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .data_valid (data_valid),
        .pending    (pending),
        .frame_start(frame_start),
        .io_seg     (io_seg),
        .io_sel     (io_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]     data;
        logic [3:0]      dp;
        logic [3:0]      blank;
        logic [3:0][7:0] seg;   // expected io_seg per digit, [3]=digit 3
        logic [3:0][3:0] sel;   // expected io_sel per digit
    } vec_t;

    vec_t vecs[4];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        data_in    = d;
        dp_in      = dp;
        blank_in   = bl;
        data_valid = 1'b1;
        tick(1);
        data_valid = 1'b0;
    endtask

    task automatic sync_frame();
        int n;
        n = 0;
        while (frame_start !== 1'b1 && n < 40) begin
            tick(1);
            n++;
        end
        chk("sync_frame_start", 32'(frame_start), 32'd1);
    endtask

    // Starts on a frame_start cycle; output on cycle k reflects scan position k-1.
    task automatic check_frame(input string tag, input logic [3:0][7:0] seg,
                               input logic [3:0][3:0] sel);
        int p;
        int d;
        int c;
        logic [7:0] es;
        logic [3:0] el;
        for (int k = 1; k <= 32; k++) begin
            tick(1);
            p = k - 1;
            d = p / 8;
            c = p % 8;
            if (c < 2) begin
                es = 8'hFF;
                el = 4'hF;
            end else begin
                es = seg[d];
                el = sel[d];
            end
            chk($sformatf("%s_seg_k%0d", tag, k), 32'(io_seg), 32'(es));
            chk($sformatf("%s_sel_k%0d", tag, k), 32'(io_sel), 32'(el));
            chk($sformatf("%s_fs_k%0d", tag, k), 32'(frame_start), (k == 32) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        logic [3:0][7:0] off_seg;
        logic [3:0][3:0] off_sel;
        off_seg = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
        off_sel = {4'hF, 4'hF, 4'hF, 4'hF};

        vecs[0] = '{16'h12AF, 4'b0100, 4'b0000,
                    {8'hF9, 8'h24, 8'h88, 8'h8E}, {4'h7, 4'hB, 4'hD, 4'hE}};
        vecs[1] = '{16'hC5E0, 4'b1001, 4'b0010,
                    {8'h46, 8'h92, 8'hFF, 8'h40}, {4'h7, 4'hB, 4'hF, 4'hE}};
        vecs[2] = '{16'h4D7B, 4'b0000, 4'b0000,
                    {8'h99, 8'hA1, 8'hF8, 8'h83}, {4'h7, 4'hB, 4'hD, 4'hE}};
        vecs[3] = '{16'h96E8, 4'b0010, 4'b0000,
                    {8'h90, 8'h82, 8'h06, 8'h80}, {4'h7, 4'hB, 4'hD, 4'hE}};

        rst        = 1'b1;
        en         = 1'b0;
        data_in    = 16'h0000;
        dp_in      = 4'h0;
        blank_in   = 4'h0;
        data_valid = 1'b0;
        tick(2);
        chk("rst_seg", 32'(io_seg), 32'hFF);
        chk("rst_sel", 32'(io_sel), 32'hF);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);

        // Nothing loaded yet: every digit stays dark.
        rst = 1'b0;
        en  = 1'b1;
        tick(1);
        chk("first_fs", 32'(frame_start), 32'd1);
        check_frame("idle", off_seg, off_sel);

        for (int i = 0; i < 4; i++) begin
            sync_frame();
            tick(5);
            load(vecs[i].data, vecs[i].dp, vecs[i].blank);
            chk($sformatf("v%0d_pend_set", i), 32'(pending), 32'd1);
            tick(25);
            chk($sformatf("v%0d_pend_hold", i), 32'(pending), 32'd1);
            tick(1);
            chk($sformatf("v%0d_pend_clr", i), 32'(pending), 32'd0);
            check_frame($sformatf("v%0d", i), vecs[i].seg, vecs[i].sel);
        end

        // Two loads in one frame: the second wins.
        sync_frame();
        tick(3);
        load(16'h1111, 4'h0, 4'h0);
        tick(4);
        load(16'h2222, 4'h0, 4'h0);
        tick(23);
        chk("two_pend_clr", 32'(pending), 32'd0);
        chk("two_fs", 32'(frame_start), 32'd1);
        check_frame("two", {8'hA4, 8'hA4, 8'hA4, 8'hA4}, {4'h7, 4'hB, 4'hD, 4'hE});

        // Load on the frame-end cycle goes straight to the display.
        sync_frame();
        tick(31);
        data_in    = 16'h0000;
        dp_in      = 4'h0;
        blank_in   = 4'b1000;
        data_valid = 1'b1;
        tick(1);
        data_valid = 1'b0;
        chk("fe_pending", 32'(pending), 32'd0);
        chk("fe_fs", 32'(frame_start), 32'd1);
        check_frame("fe", {8'hFF, 8'hC0, 8'hC0, 8'hC0}, {4'hF, 4'hB, 4'hD, 4'hE});

        // Disable during digit 2, load while disabled, then re-enable.
        sync_frame();
        tick(19);
        chk("en_d2_sel", 32'(io_sel), 32'hB);
        chk("en_d2_seg", 32'(io_seg), 32'hC0);
        en = 1'b0;
        tick(1);
        chk("en_off_sel", 32'(io_sel), 32'hF);
        chk("en_off_seg", 32'(io_seg), 32'hFF);
        chk("en_off_fs", 32'(frame_start), 32'd0);
        load(16'h0005, 4'h0, 4'b1110);
        chk("en_off_pend", 32'(pending), 32'd1);
        tick(40);
        chk("en_off_pend_held", 32'(pending), 32'd1);
        chk("en_off_sel_held", 32'(io_sel), 32'hF);
        chk("en_off_fs_held", 32'(frame_start), 32'd0);
        en = 1'b1;
        tick(1);
        chk("reen_fs", 32'(frame_start), 32'd1);
        chk("reen_pend", 32'(pending), 32'd1);
        check_frame("reen", {8'hFF, 8'hC0, 8'hC0, 8'hC0}, {4'hF, 4'hB, 4'hD, 4'hE});
        chk("reen_pend_clr", 32'(pending), 32'd0);
        check_frame("reen_new", {8'hFF, 8'hFF, 8'hFF, 8'h92}, {4'hF, 4'hF, 4'hF, 4'hE});

        // Reset with a value pending: it must never reach the display.
        sync_frame();
        tick(4);
        load(16'h8888, 4'h0, 4'h0);
        chk("rp_pend", 32'(pending), 32'd1);
        tick(3);
        chk("rp_sel_before", 32'(io_sel), 32'hE);
        rst = 1'b1;
        tick(1);
        chk("rp_pend_clr", 32'(pending), 32'd0);
        chk("rp_sel", 32'(io_sel), 32'hF);
        chk("rp_seg", 32'(io_seg), 32'hFF);
        chk("rp_fs", 32'(frame_start), 32'd0);
        rst = 1'b0;
        tick(1);
        chk("rp_restart_fs", 32'(frame_start), 32'd1);
        check_frame("rp1", off_seg, off_sel);
        check_frame("rp2", off_seg, off_sel);
        chk("rp_pend_end", 32'(pending), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_mux_driver.md
Name: seg7_mux_driver

Overview:
- Drives the 4-digit multiplexed 7-segment display on the IO shield: it produces io_seg/io_sel for the top level from a 16-bit hex value plus per-digit decimal-point and blank masks.
- Scans digits round-robin, inserting a blanking gap before each digit to suppress ghosting.
- New values are double-buffered and applied only at a frame boundary, so the display never shows a torn value.

Parameters:
- DIGIT_PERIOD, 100000: clk cycles per digit slot (1 ms at 100 MHz); must be >= BLANK_CYCLES+1.
- BLANK_CYCLES, 2000: cycles at the start of each slot with all digits off.

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  synchronous active-high reset
- en  input  1  scan enable; 0 blanks the display and holds the scan at slot 0
- data_in  input  16  hex value; nibble k shown on digit k (digit 0 = rightmost)
- dp_in  input  4  decimal-point mask; bit k lights the DP of digit k
- blank_in  input  4  bit k=1 turns digit k fully off
- data_valid  input  1  single-cycle load strobe for data_in/dp_in/blank_in
- pending  output  1  a loaded value is waiting for the frame boundary
- frame_start  output  1  one-cycle pulse when a new frame begins (slot 0, cnt 0)
- io_seg  output  8  segments, active-low; bit7=DP, bits6:0=g..a
- io_sel  output  4  digit selects, active-low; bit k = digit k

Behaviour:
- Reset:
  - cnt=0, dig=0, shadow and display regs = 0, display blank mask = 4'b1111, pending=0, frame_start=0.
  - io_seg=8'hFF, io_sel=4'hF.
- Scan:
  - cnt counts 0..DIGIT_PERIOD-1 and wraps. On wrap, dig increments mod 4 (3 -> 0).
  - Frame end is the cycle with cnt=DIGIT_PERIOD-1 and dig=3.
- Outputs are registered. The value on cycle t+1 is a function of the cnt/dig/display state on cycle t, i.e. 1 cycle latency.
- Output selection (first matching rule wins):
  - cnt < BLANK_CYCLES: io_sel=4'hF, io_seg=8'hFF.
  - Display blank bit for dig = 1: io_sel=4'hF, io_seg=8'hFF.
  - Otherwise: io_sel = ~(4'b0001 << dig), io_seg = ~{dp[dig], font(nibble dig)}.
- Font, active-high gfedcba:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- Load:
  - data_valid captures data_in/dp_in/blank_in into the shadow regs and sets pending=1 on the next cycle.
  - A further data_valid before the frame end overwrites the shadow; last write wins.
- Commit:
  - At the frame end, display regs <= shadow if pending, and pending clears.
  - If data_valid coincides with the frame end, the new input is written to both shadow and display, and pending stays 0.
- frame_start pulses on the cycle after the frame end (the first cycle of slot 0) while en=1.
- en=0:
  - Next cycle: cnt=0, dig=0, io_sel=4'hF, io_seg=8'hFF, frame_start=0.
  - Loads still capture into the shadow and pending still sets; no commit happens while en=0.
  - When en returns to 1, scanning starts at slot 0, cnt 0, with frame_start pulsing on that first cycle.
- rst mid-frame: all state returns to reset values on the next edge; a pending shadow value is discarded.
- No illegal states: dig is 2 bits; cnt width is clog2(DIGIT_PERIOD).

Test Plan (DIGIT_PERIOD=8, BLANK_CYCLES=2):
- Reset then en=1, no load -> io_sel=4'hF and io_seg=8'hFF for all cycles (all digits blanked); frame_start every 32 cycles.
- Load data_in=16'h12AF, dp_in=4'b0100, blank_in=0 mid-frame -> pending=1 until the frame end, then 0.
  - Next frame, each slot shows 2 blank cycles, then 6 cycles of:
  - digit0: io_sel=4'hE, io_seg=8'h8E
  - digit1: io_sel=4'hD, io_seg=8'h88
  - digit2: io_sel=4'hB, io_seg=8'h24 (DP on)
  - digit3: io_sel=4'h7, io_seg=8'hF9
- Two loads in one frame, 16'h1111 then 16'h2222 -> next frame shows 2 on all digits (io_seg=8'hA4 each).
- data_valid exactly at the frame end with 16'h0000, blank_in=4'b1000 -> pending stays 0; next frame digits 0-2 show io_seg=8'hC0, digit 3 io_sel=4'hF.
- en=0 during digit 2 -> outputs off next cycle. Re-enable -> frame_start on the first enabled cycle; digit 0 shown after 2 blank cycles.
- rst asserted while pending=1 -> pending=0, io_sel=4'hF next cycle; the shadow value is never displayed.
